// File: rtl/sequence_checker.sv
// Player-input checker: synchronizes and debounces buttons, compares each press against memory, reports pass/fail.
// Optional inactivity timeout is built only when SEQUENCE_CHECKER_TIMEOUT_EN is defined.
module sequence_checker #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_off,
  input  logic [3:0] level,
  input  logic [3:0] buttons,
  input  logic [1:0] expected,
  output logic [3:0] count,
  output logic       done,
  output logic       fail,
  output logic [9:0] led_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_PRESS, DEBOUNCE, COMPARE, WAIT_RELEASE, PASS, FAIL
  } state_t;

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sequence_checker: cycle limits must be at least 1");
  end

  state_t            state_reg;
  logic [3:0]        sync1_reg, sync2_reg;
  logic [3:0]        count_reg, level_q_reg;
  logic              done_reg, fail_reg;
  logic [9:0]        led_reg;
  logic [1:0]        sel_reg;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  logic [3:0]        btn_s, sel_onehot;
  logic              btn_one, btn_multi, db_last, to_last, level_ok;
  logic [1:0]        btn_idx;

  assign btn_s     = sync2_reg;
  assign btn_one   = (btn_s != 4'd0) && ((btn_s & (btn_s - 4'd1)) == 4'd0);
  assign btn_multi = (btn_s != 4'd0) && !btn_one;
  assign level_ok  = (level != 4'd0) && (level <= 4'd10);

  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign sel_onehot[gi] = (sel_reg == 2'(gi));
  end

  always_comb begin
    btn_idx = 2'd0;
    case (btn_s)
      4'b0010: btn_idx = 2'd1;
      4'b0100: btn_idx = 2'd2;
      4'b1000: btn_idx = 2'd3;
      default: btn_idx = 2'd0;
    endcase
  end

  // Saturating debounce counter; the state leaves before it would ever wrap.
  assign db_last     = (db_cnt_reg >= DB_W'(DEBOUNCE_CYCLES - 1));
  assign db_cnt_next = (db_cnt_reg >= DB_W'(DEBOUNCE_CYCLES)) ? db_cnt_reg : db_cnt_reg + 1'b1;

`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  assign to_last     = (to_cnt_reg >= TO_W'(TIMEOUT_CYCLES - 1));
  assign to_cnt_next = (to_cnt_reg >= TO_W'(TIMEOUT_CYCLES)) ? to_cnt_reg : to_cnt_reg + 1'b1;
`else
  assign to_last = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 4'd0;
      sync2_reg <= 4'd0;
    end else begin
      sync1_reg <= buttons;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || !on_off) begin
      // Reset and disable share one clear path; disable just waits for the edge.
      state_reg   <= IDLE;
      count_reg   <= 4'd0;
      level_q_reg <= 4'd0;
      done_reg    <= 1'b0;
      fail_reg    <= 1'b0;
      led_reg     <= 10'd0;
      sel_reg     <= 2'd0;
      db_cnt_reg  <= '0;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
      to_cnt_reg  <= '0;
`endif
    end else begin
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
      if (state_reg == WAIT_PRESS || state_reg == DEBOUNCE) to_cnt_reg <= to_cnt_next;
`endif
      case (state_reg)
        IDLE: begin
          if (level_ok) begin
            level_q_reg <= level;
            state_reg   <= WAIT_PRESS;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
            to_cnt_reg  <= '0;
`endif
          end
        end
        WAIT_PRESS: begin
          if (btn_one) begin
            sel_reg    <= btn_idx;
            db_cnt_reg <= '0;
            state_reg  <= DEBOUNCE;
          end else if (btn_multi || to_last) begin
            state_reg <= FAIL;
            done_reg  <= 1'b1;
            fail_reg  <= 1'b1;
            led_reg   <= 10'h3FF;
          end
        end
        DEBOUNCE: begin
          if (btn_s != sel_onehot) state_reg <= WAIT_PRESS;
          else if (db_last)        state_reg <= COMPARE;
          else                     db_cnt_reg <= db_cnt_next;
        end
        COMPARE: begin
          if (sel_reg == expected) begin
            led_reg    <= {6'd0, sel_onehot};
            db_cnt_reg <= '0;
            state_reg  <= WAIT_RELEASE;
          end else begin
            state_reg <= FAIL;
            done_reg  <= 1'b1;
            fail_reg  <= 1'b1;
            led_reg   <= 10'h3FF;
          end
        end
        WAIT_RELEASE: begin
          if (btn_s != 4'd0) begin
            db_cnt_reg <= '0;
          end else if (db_last) begin
            led_reg    <= 10'd0;
            count_reg  <= count_reg + 4'd1;
            db_cnt_reg <= '0;
            if (count_reg + 4'd1 == level_q_reg) begin
              state_reg <= PASS;
              done_reg  <= 1'b1;
              fail_reg  <= 1'b0;
            end else begin
              state_reg <= WAIT_PRESS;
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
              to_cnt_reg <= '0;
`endif
            end
          end else begin
            db_cnt_reg <= db_cnt_next;
          end
        end
        PASS, FAIL: ;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign count   = count_reg;
  assign done    = done_reg;
  assign fail    = fail_reg;
  assign led_out = led_reg;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed scenarios plus randomized press sequences scored by a step-level model.
module tb_sequence_checker;
  localparam int DB = 4;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       on_off = 1'b0;
  logic [3:0] level = 4'd0;
  logic [3:0] buttons = 4'd0;
  logic [1:0] expected;
  logic [3:0] count;
  logic       done, fail;
  logic [9:0] led_out;
  logic [1:0] mem [0:15];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign expected = mem[count];

  sequence_checker #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .on_off(on_off), .level(level), .buttons(buttons),
    .expected(expected), .count(count), .done(done), .fail(fail), .led_out(led_out)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] lvl);
    on_off = 1'b0; buttons = 4'd0;
    tick(2);
    level = lvl; on_off = 1'b1;
    tick(1);
  endtask

  task automatic press_release(input logic [3:0] b);
    buttons = b; tick(10);
    buttons = 4'd0; tick(10);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 2'd0;
    tick(3);
    chk("reset_count", 32'(count), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_fail", 32'(fail), 0);
    chk("reset_led", 32'(led_out), 0);
    reset = 1'b1;
    tick(1);

    // Correct three-step sequence
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    start(4'd3);
    buttons = 4'b0100; tick(10); chk("seq_led0", 32'(led_out), 32'h004);
    buttons = 4'b0000; tick(10); chk("seq_led0_off", 32'(led_out), 0);
    buttons = 4'b0001; tick(10); chk("seq_led1", 32'(led_out), 32'h001);
    buttons = 4'b0000; tick(10);
    buttons = 4'b1000; tick(10); chk("seq_led2", 32'(led_out), 32'h008);
    buttons = 4'b0000; tick(10);
    chk("seq_count", 32'(count), 3);
    chk("seq_done", 32'(done), 1);
    chk("seq_fail", 32'(fail), 0);

    // Wrong press on the second step
    mem[0] = 2'd1; mem[1] = 2'd2;
    start(4'd2);
    press_release(4'b0010);
    press_release(4'b0001);
    chk("wrong_done", 32'(done), 1);
    chk("wrong_fail", 32'(fail), 1);
    chk("wrong_count", 32'(count), 1);
    chk("wrong_led", 32'(led_out), 32'h3FF);

    // Glitch rejection, then a real press
    mem[0] = 2'd0;
    start(4'd1);
    buttons = 4'b0001; tick(2);
    buttons = 4'b0000; tick(10);
    chk("glitch_count", 32'(count), 0);
    chk("glitch_done", 32'(done), 0);
    chk("glitch_led", 32'(led_out), 0);
    buttons = 4'b0001; tick(10); chk("glitch_led_ok", 32'(led_out), 32'h001);
    buttons = 4'b0000; tick(10);
    chk("glitch_pass_done", 32'(done), 1);
    chk("glitch_pass_fail", 32'(fail), 0);
    chk("glitch_pass_count", 32'(count), 1);

    // Inactivity timeout
    start(4'd1);
    tick(90);
    chk("timeout_early_done", 32'(done), 0);
    tick(20);
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
    chk("timeout_done", 32'(done), 1);
    chk("timeout_fail", 32'(fail), 1);
    chk("timeout_count", 32'(count), 0);
`else
    tick(400);
    chk("no_timeout_done", 32'(done), 0);
`endif

    // Multi-button press
    start(4'd2);
    buttons = 4'b0011; tick(10);
    chk("multi_done", 32'(done), 1);
    chk("multi_fail", 32'(fail), 1);
    chk("multi_led", 32'(led_out), 32'h3FF);
    chk("multi_count", 32'(count), 0);

    // Abort mid-debounce on the second step
    mem[0] = 2'd1; mem[1] = 2'd2;
    start(4'd2);
    press_release(4'b0010);
    chk("abort_pre_count", 32'(count), 1);
    buttons = 4'b0100; tick(4);
    on_off = 1'b0; tick(1);
    chk("abort_count", 32'(count), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_led", 32'(led_out), 0);
    start(4'd2);
    buttons = 4'b0010; tick(10); chk("abort_restart_led", 32'(led_out), 32'h002);
    buttons = 4'b0000; tick(10);
    chk("abort_restart_count", 32'(count), 1);

    // Asynchronous reset while waiting for release
    mem[0] = 2'd3; mem[1] = 2'd1;
    start(4'd2);
    press_release(4'b1000);
    buttons = 4'b0010; tick(10);
    chk("areset_pre_led", 32'(led_out), 32'h002);
    chk("areset_pre_count", 32'(count), 1);
    #2 reset = 1'b0;
    #1;
    chk("areset_count", 32'(count), 0);
    chk("areset_led", 32'(led_out), 0);
    chk("areset_done", 32'(done), 0);
    chk("areset_fail", 32'(fail), 0);
    buttons = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(1);

    // Invalid levels never leave idle
    start(4'd0);
    tick(50);
    chk("lvl0_done", 32'(done), 0);
    chk("lvl0_count", 32'(count), 0);
    start(4'd11);
    buttons = 4'b0001; tick(10); buttons = 4'b0000; tick(40);
    chk("lvl11_done", 32'(done), 0);
    chk("lvl11_led", 32'(led_out), 0);

    // Randomized sequences: model tracks the step and outcome per press
    for (int t = 0; t < 20; t++) begin
      int lvl, step, i, j, idx;
      bit ended, failed;
      logic [3:0] b;
      lvl = $urandom_range(1, 10);
      for (int k = 0; k < 16; k++) mem[k] = 2'($urandom_range(0, 3));
      start(4'(lvl));
      step = 0; ended = 0; failed = 0;
      while (!ended) begin
        case ($urandom_range(0, 9))
          0: begin
            i = $urandom_range(0, 3);
            j = (i + $urandom_range(1, 3)) % 4;
            b = 4'((1 << i) | (1 << j));
          end
          1: b = 4'(1 << ((int'(mem[step]) + $urandom_range(1, 3)) % 4));
          default: b = 4'(1 << mem[step]);
        endcase
        buttons = b; tick(10);
        idx = (b == 4'b0001) ? 0 : (b == 4'b0010) ? 1 : (b == 4'b0100) ? 2 : 3;
        if ($countones(b) != 1 || idx != int'(mem[step])) begin
          failed = 1; ended = 1;
          chk("rand_led_fail", 32'(led_out), 32'h3FF);
        end else begin
          chk("rand_led_echo", 32'(led_out), 32'(1 << idx));
          step++;
          if (step == lvl) ended = 1;
        end
        buttons = 4'd0; tick(10);
        chk("rand_count", 32'(count), 32'(step));
        chk("rand_done", 32'(done), 32'(ended));
        chk("rand_fail", 32'(fail), 32'(failed));
      end
      chk("rand_led_end", 32'(led_out), failed ? 32'h3FF : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Player-input side of the game; complement to the LED blinker.
- Once the blinker finishes, the FSM enables this block. It reads the player's button presses, synchronizes and debounces them, and checks each one against the stored sequence. It reads simple_memory through the same count-as-address scheme the blinker uses.
- It reports pass or fail back to the FSM.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles a button level must hold before it is accepted (20 ms at 50 MHz; benches use 4).
- TIMEOUT_CYCLES, 250_000_000, inactivity limit while waiting for a press (5 s at 50 MHz; benches use 100).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- on_off  in  1  enable from the FSM; must stay high for the whole check.
- level  in  4  number of steps to check, from the FSM; valid range 1..10.
- buttons  in  4  raw player buttons, active-high, asynchronous to clk.
- expected  in  2  LED index from simple_memory at address count; memory read is combinational.
- count  out  4  current step, which is also the memory address.
- done  out  1  check finished (pass or fail), held high.
- fail  out  1  qualifies done: 1 means wrong press or timeout.
- led_out  out  10  echo of the accepted button / fail indication.

Behaviour:
- Reset values: count=0, done=0, fail=0, led_out=0, state=IDLE, all counters 0, synchronizer flops 0.
- buttons pass through a 2-flop synchronizer; "btn_s" below means the synchronized value (2-cycle latency).
- level_q is captured on IDLE exit; changes to level afterwards are ignored.
- on_off==0 in any state: go to IDLE next cycle and clear count, done, fail, led_out and all counters.

States:
- IDLE: outputs cleared. Go to WAIT_PRESS when on_off==1 and 1<=level<=10. level 0 or level>10 stays in IDLE.
- WAIT_PRESS: the timeout counter increments each cycle.
  - Exactly one bit of btn_s set: latch its index as sel, clear the debounce counter, go to DEBOUNCE.
  - Two or more bits set: go to FAIL.
  - Timeout counter reaches TIMEOUT_CYCLES: go to FAIL.
- DEBOUNCE: the debounce counter increments while btn_s equals the one-hot of sel; the timeout counter keeps running.
  - btn_s differs: glitch rejected, return to WAIT_PRESS without clearing the timeout counter.
  - Debounce counter reaches DEBOUNCE_CYCLES: go to COMPARE.
- COMPARE (1 cycle):
  - sel==expected: led_out <= {6'd0, one-hot(sel)}, go to WAIT_RELEASE.
  - sel!=expected: go to FAIL.
- WAIT_RELEASE: led_out stays lit.
  - btn_s must be 0 for DEBOUNCE_CYCLES consecutive cycles; any nonzero value restarts the count.
  - On completion: led_out<=0 and count<=count+1.
  - If count+1==level_q: go to PASS. Otherwise go to WAIT_PRESS with the timeout counter cleared.
- PASS: done=1, fail=0, count==level_q. Held until on_off drops.
- FAIL: done=1, fail=1, led_out=10'h3FF, count frozen at the failing step. Held until on_off drops.

Timing and widths:
- Minimum latency from a raw press edge to COMPARE is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Counters are sized by $clog2 of their limits and saturate, never wrap.
- count never exceeds 10.

Optional Feature:
- Macro: SEQUENCE_CHECKER_TIMEOUT_EN.
- Defined: the inactivity timeout is active as described above.
- Not defined:
  - The timeout counter is not built and TIMEOUT_CYCLES is unused.
  - WAIT_PRESS waits indefinitely; FAIL is reached only on a wrong press or a multi-button press.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100):
- Correct 3-step sequence: level=3, memory={2,0,3}; press buttons 4'b0100, 4'b0001, 4'b1000, each held 10 cycles and released 10 cycles.
  - led_out shows 10'h004, 10'h001, 10'h008 in turn.
  - End state: count=3, done=1, fail=0.
- Wrong press: level=2, memory={1,2}; press 4'b0010 then 4'b0001.
  - done=1, fail=1, count=1, led_out=10'h3FF.
- Glitch rejection: a 2-cycle pulse on buttons[0] gives no state advance and count stays 0; a following 10-cycle press of the correct button is accepted.
- Timeout (macro defined): level=1, no press for 100 cycles after enable gives done=1, fail=1, count=0. With the macro undefined, done stays 0 after 500 cycles.
- Multi-press: buttons=4'b0011 held 10 cycles gives FAIL.
- Abort and reset:
  - Drop on_off mid-DEBOUNCE: one cycle later count=0, done=0, led_out=0, and a re-enable restarts from step 0.
  - Assert reset=0 asynchronously mid-WAIT_RELEASE: all outputs clear without waiting for a clk edge.
- Invalid level: level=0 or level=11 with on_off=1 keeps the block in IDLE and done stays 0 for 50 cycles.
